// File: rtl/dff_arb_pkg.sv
// Shared types and helpers for the round-robin register arbiter.
package dff_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  // Widest requester vector the rotate helpers handle.
  localparam int MAX_REQ = 32;

  // Pointer/index width for n requesters, never narrower than one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Rotate right by sh within the low n bits: r[i] = v[(i+sh) mod n].
  // sh is expected in [0, n).
  function automatic logic [MAX_REQ-1:0] rotr(input logic [MAX_REQ-1:0] v,
                                              input int sh, input int n);
    logic [MAX_REQ-1:0] r;
    int j;
    r = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        j = i + sh;
        if (j >= n) j = j - n;
        r[i] = v[j];
      end
    end
    return r;
  endfunction

  // Inverse of rotr: r[(i+sh) mod n] = v[i].
  function automatic logic [MAX_REQ-1:0] rotl(input logic [MAX_REQ-1:0] v,
                                              input int sh, input int n);
    logic [MAX_REQ-1:0] r;
    int j;
    r = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        j = i + sh;
        if (j >= n) j = j - n;
        r[j] = v[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request after i_last, wrapping.
module rr_pick
  import dff_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = ptr_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_last,
  output logic [N_REQ-1:0] o_onehot,
  output logic [PW-1:0]    o_idx
);

  int               w_start;
  logic [N_REQ-1:0] w_rot;
  logic [N_REQ-1:0] w_prio;

  // Rotate so the search start sits at bit 0, take lowest set bit, rotate back.
  always_comb begin
    w_start  = (int'(i_last) >= N_REQ - 1) ? 0 : int'(i_last) + 1;
    w_rot    = N_REQ'(rotr(MAX_REQ'(i_req), w_start, N_REQ));
    w_prio   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_prio = N_REQ'(1) << i;
    end
    o_onehot = N_REQ'(rotl(MAX_REQ'(w_prio), w_start, N_REQ));
    o_idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (o_onehot[i]) o_idx = PW'(i);
    end
  end

endmodule

// File: rtl/dff_rr_arbiter.sv
// Round-robin arbiter that sequences writes into one shared W-bit register.
module dff_rr_arbiter
  import dff_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int HOLD  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   din,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         ack,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic [WIDTH-1:0]         dout
);

  localparam int PW = ptr_w(N_REQ);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_last;
  logic [PW-1:0]    r_owner;
  logic [N_REQ-1:0] r_gnt;
  logic [WIDTH-1:0] r_dout;

  logic [N_REQ-1:0] w_onehot;
  logic [PW-1:0]    w_idx;

  rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .i_req    (req),
    .i_last   (r_last),
    .o_onehot (w_onehot),
    .o_idx    (w_idx)
  );

  // Grant/hold/release sequencer; requests are only looked at while IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= PW'(N_REQ - 1);
      r_owner <= '0;
      r_gnt   <= '0;
      r_dout  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_gnt   <= w_onehot;
            r_owner <= w_idx;
            r_dout  <= din[int'(w_idx)*WIDTH +: WIDTH];
            r_cnt   <= CW'(HOLD - 1);
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_gnt   <= '0;
            r_last  <= r_owner;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Ack decodes purely from registered state so it cannot glitch.
  assign ack   = (r_state == BUSY && r_cnt == '0) ? r_gnt : '0;
  assign busy  = (r_state == BUSY);
  assign gnt   = r_gnt;
  assign owner = r_owner;
  assign dout  = r_dout;

endmodule

// File: tb/tb_dff_rr_arbiter.sv
// Scoreboard bench for dff_rr_arbiter (N_REQ=4, WIDTH=8, HOLD=2).
module tb_dff_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int H = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] din = '0;
  logic [N-1:0] gnt, ack;
  logic         busy;
  logic [1:0]   owner;
  logic [W-1:0] dout;

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         gap;   // expected cycles since previous ack, 0 = unchecked
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  dff_rr_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD(H)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .gnt(gnt), .ack(ack), .busy(busy), .owner(owner), .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int idx, input logic [7:0] data, input int gap);
    exp_t e;
    e.idx = idx; e.data = data; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic set_din(input int i, input logic [7:0] v);
    din[i*W +: W] = v;
  endtask

  // Wait (bounded) for ack[i], then return 1ns into the following cycle.
  task automatic wait_ack(input int i);
    int t;
    t = 0;
    @(negedge clk);
    while (!ack[i] && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (!ack[i]) begin
      n_chk++; n_fail++;
      $display("FAIL ack_timeout: requester %0d got no ack", i);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_gnt(input logic [N-1:0] g);
    int t;
    t = 0;
    @(negedge clk);
    while (gnt !== g && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("gnt_seen", gnt, g);
  endtask

  // Monitor: every ack pops one expected transaction and checks it.
  initial begin
    int cyc, last_ack, len;
    exp_t e;
    cyc = 0; last_ack = 0; len = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        len = 0;
      end else begin
        if (gnt != '0) len++; else len = 0;
        if (ack != '0) begin
          if (q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_ack: got %0h expected none", ack);
          end else begin
            e = q.pop_front();
            chk("ack_owner", 32'(owner), 32'(e.idx));
            chk("ack_dout",  32'(dout),  32'(e.data));
            chk("ack_vec",   32'(ack),   32'(1) << e.idx);
            chk("ack_gnt",   32'(gnt),   32'(1) << e.idx);
            chk("hold_len",  32'(len),   32'(H));
            if (e.gap != 0) chk("ack_gap", 32'(cyc - last_ack), 32'(e.gap));
          end
          last_ack = cyc;
        end
      end
    end
  end

  initial begin
    // Reset held with random inputs: outputs stay at zero.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      req = N'($urandom);
      din = $urandom;
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_owner", 32'(owner), 0);
      chk("rst_dout", 32'(dout), 0);
    end
    @(posedge clk); #1;
    req = '0;
    rst = 1'b0;

    // Fairness from reset: all four keep requesting.
    set_din(0, 8'h11); set_din(1, 8'h22); set_din(2, 8'h33); set_din(3, 8'h44);
    push(0, 8'h11, 0); push(1, 8'h22, 3); push(2, 8'h33, 3);
    push(3, 8'h44, 3); push(0, 8'h11, 3); push(1, 8'h22, 3);
    req = 4'b1111;
    wait_ack(0); wait_ack(1); wait_ack(2); wait_ack(3); wait_ack(0); wait_ack(1);
    req = '0;
    @(posedge clk); #1;

    // Single request with exact timing: grant and dout one cycle after sampling.
    set_din(0, 8'hA5);
    push(0, 8'hA5, 0);
    req = 4'b0001;
    @(negedge clk);
    chk("single_pre_gnt", 32'(gnt), 0);
    @(negedge clk);
    chk("single_gnt1", 32'(gnt), 32'b0001);
    chk("single_dout1", 32'(dout), 32'hA5);
    chk("single_ack1", 32'(ack), 0);
    chk("single_busy1", 32'(busy), 1);
    wait_ack(0);
    req = '0;
    @(negedge clk);
    chk("single_idle_busy", 32'(busy), 0);
    chk("single_idle_dout", 32'(dout), 32'hA5);
    @(posedge clk); #1;

    // Pointer wrap: after 2 completes, 4'b0101 goes to 0 then 2.
    set_din(2, 8'hC3);
    push(2, 8'hC3, 0);
    req = 4'b0100;
    wait_ack(2);
    set_din(0, 8'h5A); set_din(2, 8'h3C);
    push(0, 8'h5A, 3); push(2, 8'h3C, 3);
    req = 4'b0101;
    wait_ack(0);
    req = 4'b0100;
    wait_ack(2);
    req = '0;
    @(posedge clk); #1;

    // Dropped request: 3 lets go mid-grant but still completes with its data.
    set_din(3, 8'hE7);
    push(3, 8'hE7, 0);
    req = 4'b1000;
    wait_gnt(4'b1000);
    @(posedge clk); #1;
    req = '0;
    set_din(3, 8'hFF);
    wait_ack(3);
    chk("drop_dout_after", 32'(dout), 32'hE7);

    // Reset mid-BUSY of requester 1: immediate clear, no ack.
    set_din(1, 8'h77);
    req = 4'b0010;
    wait_gnt(4'b0010);
    #1 rst = 1'b1;
    #1;
    chk("mrst_gnt", 32'(gnt), 0);
    chk("mrst_ack", 32'(ack), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_owner", 32'(owner), 0);
    chk("mrst_dout", 32'(dout), 0);
    @(posedge clk); #1;
    set_din(0, 8'h99);
    req = 4'b0011;
    push(0, 8'h99, 0); push(1, 8'h77, 3);
    rst = 1'b0;
    wait_ack(0);
    req = 4'b0010;
    wait_ack(1);
    req = '0;

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 0);
    chk("final_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dff_rr_arbiter.md
# dff_rr_arbiter

Round-robin arbiter and write sequencer for a shared W-bit flip-flop register. Up to N_REQ requesters each present a request and a data word; the block grants one at a time, loads the winner's word into the shared register, holds ownership for a fixed number of cycles, then acknowledges and releases. It sits in front of the register stage and turns it into a shared, sequenced resource.

## Interface
- N_REQ, default 4: number of requesters, ≥2.
- WIDTH, default 8: register data width.
- HOLD, default 2: cycles a grant is held, ≥1.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  N_REQ  per-requester request level; held high until own ack.
- din  in  N_REQ*WIDTH  packed data; requester i at bits [i*WIDTH +: WIDTH].
- gnt  out  N_REQ  one-hot grant, all-zero when idle.
- ack  out  N_REQ  one-cycle completion pulse to the owner.
- busy  out  1  high while a grant is active.
- owner  out  $clog2(N_REQ)  index of the current or last granted requester.
- dout  out  WIDTH  shared register contents.

## Operation
- FSM states: IDLE, BUSY. Reset state IDLE.
- Reset values: gnt=0, ack=0, busy=0, owner=0, dout=0, cnt=0. Round-robin pointer last=N_REQ-1, so requester 0 has first priority.
- IDLE with req==0: remain in IDLE. All outputs hold, and dout keeps its last value.
- IDLE with any req bit set, at the rising edge:
  - Winner is the first set bit searching from index last+1 upward, wrapping modulo N_REQ.
  - gnt becomes onehot(winner), owner becomes winner, dout captures din[winner], cnt loads HOLD-1.
  - Next state is BUSY.
- BUSY with cnt≠0: decrement cnt. req and din are ignored.
- BUSY with cnt==0:
  - ack[i] = gnt[i], decoded from registered state so it is glitch-free.
  - At the edge that ends this cycle: gnt cleared, last becomes owner, next state IDLE.
- busy equals (state==BUSY).
- A requester that drops req during BUSY still completes, and its ack still pulses.
- Requests raised during BUSY are only considered in the following IDLE cycle.
- Arithmetic: cnt is $clog2(HOLD) bits wide (minimum 1). The pointer increment wraps modulo N_REQ; for non-power-of-two N_REQ the wrap is explicit, not an overflow.
- rst asserted in any state clears every output and all state immediately, with no clock edge. An in-flight transaction is abandoned and produces no ack.

## Timing
- req sampled high at edge k while IDLE:
  - gnt and busy are high for cycles k+1 through k+HOLD.
  - dout is valid from cycle k+1.
  - ack is high in cycle k+HOLD only.
- Minimum one IDLE cycle between grants, so peak throughput is one grant per HOLD+1 cycles.
- A requester that deasserts req on the edge after its ack is not re-granted. A requester that keeps req high is eligible again, but only after the other requesters in round-robin order.
- HOLD=1: gnt and ack coincide in a single cycle.
- Latency from req to dout update is one edge.

## Structure
- Package dff_arb_pkg contains:
  - the state enum typedef (IDLE, BUSY);
  - localparam helpers for pointer width;
  - a rotate-left/rotate-right function on N_REQ-bit vectors.
- Sub-module rr_pick: combinational; inputs req and last, outputs a one-hot winner and its index.
  - Implementation: rotate, fixed priority, unrotate.
  - Reusable by other arbiters in the codebase.
- The top level holds the FSM, cnt, pointer and dout register.

## Test plan
- Reset: hold rst=1 with random req/din. Required: gnt=0, ack=0, busy=0, owner=0, dout=8'h00 throughout; after release, first grant goes to requester 0 when req=4'b1111.
- Single request (N_REQ=4, WIDTH=8, HOLD=2): req=4'b0001, din0=8'hA5. Required:
  - gnt=4'b0001 for 2 cycles, from the cycle after the sampling edge;
  - dout=8'hA5 from the first grant cycle;
  - ack=4'b0001 in the second grant cycle only.
- Fairness: all four requesters keep req high, each re-raising after its ack. Required: grant order 0,1,2,3,0,1, with exactly one IDLE cycle between grants.
- Pointer wrap: after a grant to requester 2 completes, apply req=4'b0101. Required: requester 0 is granted next (search order 3,0), then requester 2.
- Reset mid-BUSY: assert rst asynchronously during the first BUSY cycle of requester 1. Required:
  - all outputs drop to 0 immediately, with no ack pulse;
  - after release with req=4'b0011, requester 0 is granted first.
- Dropped request: requester 3 deasserts req during BUSY. Required: gnt stays 4'b1000 for HOLD cycles, ack[3] still pulses, and dout keeps the captured value.
